lcd_spi_sequencer: RTL and testbench
====================================

LCD_SPI_SEQUENCER -- requirements
Module: lcd_spi_sequencer

Interface
REQ-001 Parameter CLK_FREQ, default 100000000: system clock frequency in Hz; sets the 1 ms delay tick.
REQ-002 Parameter FIFO_DEPTH, default 8: entries in the request FIFO; power of two, 2 to 64.
REQ-003 CLK_100MHz  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wr_en  in  1  push request word when high and full=0.
REQ-006 wr_data  in  10  request word {op[1:0], payload[7:0]}: op 00 command byte, 01 data byte, 10 delay payload ms, 11 panel reset pulse payload ms.
REQ-007 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-008 idle  out  1  FIFO empty, state IDLE, spi_busy=0.
REQ-009 overflow  out  1  sticky; set when wr_en=1 while full=1.
REQ-010 spi_load  out  1  one-cycle start strobe to the SPI byte engine.
REQ-011 spi_data  out  8  byte for the SPI engine; valid while spi_load=1.
REQ-012 spi_busy  in  1  engine busy; rises the cycle after spi_load and falls after CSX deasserts.
REQ-013 DCX  out  1  panel data/command select: 0 command, 1 data.
REQ-014 RESX  out  1  panel hardware reset, active low.

Function
REQ-015 FIFO: write accepted when wr_en=1 and full=0, including a same-cycle pop; a write while full is dropped and sets overflow.
REQ-016 States: IDLE, LOAD, WAIT_START, WAIT_DONE, DELAY, PULSE.
REQ-017 IDLE: when FIFO not empty and spi_busy=0, pop the head into the current-word register, then go to LOAD for op 00/01, DELAY for op 10, PULSE for op 11.
REQ-018 On a pop of op 00/01, DCX updates on the same edge to op[0] and holds until the next byte op is popped.
REQ-019 LOAD: spi_load=1 and spi_data=payload for exactly one cycle, then WAIT_START.
REQ-020 WAIT_START: remain until spi_busy=1, then WAIT_DONE; WAIT_DONE: remain until spi_busy=0, then IDLE.
REQ-021 spi_load=0 in every state except LOAD; spi_data holds its last value outside LOAD.
REQ-022 Delay tick: a counter wraps every CLK_FREQ/1000 cycles, restarting at 0 on entry to DELAY or PULSE; the ms count is 8 bits and does not wrap.
REQ-023 DELAY: wait payload ms; payload 0 returns to IDLE after one cycle in DELAY.
REQ-024 PULSE: RESX=0 for max(payload,1) ms, then RESX=1 and return to IDLE; DCX unchanged.
REQ-025 Byte-to-byte minimum gap is 2 cycles after spi_busy falls (IDLE, LOAD); back-to-back entries need no host wait.
REQ-026 FIFO ordering is strict; a delay or pulse blocks subsequent bytes until it completes.

Reset
REQ-027 While reset=1: FIFO empty, state IDLE, spi_load=0, spi_data=0, DCX=1, RESX=1, overflow=0, full=0, and all counters 0.
REQ-028 Reset mid-byte does not stop the SPI engine, which has no reset; after release, IDLE issues no spi_load until spi_busy=0.
REQ-029 Reset mid-PULSE returns RESX to 1 asynchronously.

Structure
REQ-030 Shared package holds the op encodings (OP_CMD, OP_DATA, OP_DELAY, OP_RESET), the state encoding, and the 10-bit request word width.
REQ-031 The FIFO is one sub-module, sync_fifo (parameterised width and depth, registered count, full/empty flags); sequencing logic is in lcd_spi_sequencer.

Verification
REQ-032 Bench uses CLK_FREQ=1000000 (1000 cycles/ms) and a behavioural engine model with busy asserted 1 cycle after load for 20 cycles.
REQ-033 Push {00,0x2A} -> DCX=0, one spi_load pulse with spi_data=0x2A, idle=1 about 23 cycles later.
REQ-034 Push {00,0x2C},{01,0xF8},{01,0x00} back-to-back -> three spi_load pulses in order; DCX 0,1,1; exactly 2-cycle gap after each busy fall.
REQ-035 Push {11,0x05},{10,0x00},{00,0x11} -> RESX low for exactly 5000 cycles; 0-ms delay takes 1 cycle; then spi_data=0x11 with DCX=0.
REQ-036 Push 9 words with engine stalled (busy held high) -> full=1 after 8; the 9th is dropped and overflow=1; after release, exactly 8 bytes are sent.
REQ-037 Assert reset during WAIT_DONE with busy still high -> outputs reach reset values immediately; a new push is not loaded until model busy falls.

Source files
------------

// File: rtl/lcd_spi_sequencer_pkg.sv
// Shared definitions for the LCD SPI command sequencer: request word layout,
// op encodings and sequencer state encoding.
package lcd_spi_sequencer_pkg;

   localparam int WORD_W = 10;

   localparam logic [1:0] OP_CMD   = 2'b00;
   localparam logic [1:0] OP_DATA  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_RESET = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD       = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_DELAY      = 3'd4,
      ST_PULSE      = 3'd5
   } state_t;

   function automatic logic [1:0] word_op(input logic [WORD_W-1:0] w);
      return w[9:8];
   endfunction

   function automatic logic [7:0] word_payload(input logic [WORD_W-1:0] w);
      return w[7:0];
   endfunction

   // A zero-length panel reset would be meaningless, so it is stretched to 1 ms.
   function automatic logic [7:0] pulse_ms(input logic [7:0] payload);
      return (payload == 8'd0) ? 8'd1 : payload;
   endfunction

endpackage

// File: rtl/lcd_spi_sequencer_sync_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy count.
// Writes while full are ignored; reads while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_push    = i_wr_en && !o_full;
   assign w_pop     = i_rd_en && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr];

   // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// Drains a queue of panel requests (command/data bytes, ms delays, reset pulses)
// into a byte-wide SPI engine and drives the panel DCX/RESX pins.
module lcd_spi_sequencer
   import lcd_spi_sequencer_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              CLK_100MHz,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   output logic              full,
   output logic              idle,
   output logic              overflow,
   output logic              spi_load,
   output logic [7:0]        spi_data,
   input  logic              spi_busy,
   output logic              DCX,
   output logic              RESX
);

   localparam int TICK_CYCLES = CLK_FREQ / 1000;
   localparam int TICK_W      = $clog2(TICK_CYCLES + 1);

   state_t            r_state;
   logic [7:0]        r_payload;
   logic [TICK_W-1:0] r_tick;
   logic [7:0]        r_ms;
   logic              r_spi_load;
   logic [7:0]        r_spi_data;
   logic              r_dcx;
   logic              r_resx;
   logic              r_overflow;

   logic [WORD_W-1:0] w_head;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_tick_wrap;

   sync_fifo #(
      .WIDTH(WORD_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk    (CLK_100MHz),
      .i_rst    (reset),
      .i_wr_en  (wr_en),
      .i_wr_data(wr_data),
      .i_rd_en  (w_pop),
      .o_rd_data(w_head),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   // Never start a new request while the engine still reports busy (covers reset mid-byte).
   assign w_pop       = (r_state == ST_IDLE) && !w_empty && !spi_busy;
   assign w_tick_wrap = (r_tick == TICK_W'(TICK_CYCLES - 1));

   assign full     = w_full;
   assign idle     = (r_state == ST_IDLE) && w_empty && !spi_busy;
   assign overflow = r_overflow;
   assign spi_load = r_spi_load;
   assign spi_data = r_spi_data;
   assign DCX      = r_dcx;
   assign RESX     = r_resx;

   // Sequencer FSM with registered panel and engine outputs.
   always_ff @(posedge CLK_100MHz or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_payload  <= 8'd0;
         r_tick     <= '0;
         r_ms       <= 8'd0;
         r_spi_load <= 1'b0;
         r_spi_data <= 8'd0;
         r_dcx      <= 1'b1;
         r_resx     <= 1'b1;
      end else begin
         r_spi_load <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_payload <= word_payload(w_head);
                  r_tick    <= '0;
                  r_ms      <= 8'd0;
                  case (word_op(w_head))
                     OP_CMD, OP_DATA: begin
                        r_dcx      <= w_head[8];
                        r_spi_load <= 1'b1;
                        r_spi_data <= word_payload(w_head);
                        r_state    <= ST_LOAD;
                     end
                     OP_DELAY: begin
                        r_state <= ST_DELAY;
                     end
                     default: begin
                        r_resx  <= 1'b0;
                        r_state <= ST_PULSE;
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               r_state <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (spi_busy) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!spi_busy) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DELAY: begin
               if (r_ms == r_payload) begin
                  r_state <= ST_IDLE;
               end else if (w_tick_wrap) begin
                  r_tick <= '0;
                  if (r_ms != 8'hFF) begin
                     r_ms <= r_ms + 8'd1;
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end
            ST_PULSE: begin
               // Release on the last cycle of the final ms so RESX is low for exactly N ms.
               if (w_tick_wrap && (r_ms == (pulse_ms(r_payload) - 8'd1))) begin
                  r_tick  <= '0;
                  r_resx  <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_tick_wrap) begin
                  r_tick <= '0;
                  if (r_ms != 8'hFF) begin
                     r_ms <= r_ms + 8'd1;
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky record of any request dropped because the queue was full.
   always_ff @(posedge CLK_100MHz or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (wr_en && w_full) begin
         r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Directed, table-driven bench for lcd_spi_sequencer with a behavioural SPI engine.
module tb_lcd_spi_sequencer;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [9:0] wr_data;
   logic       full;
   logic       idle;
   logic       overflow;
   logic       spi_load;
   logic [7:0] spi_data;
   logic       spi_busy;
   logic       DCX;
   logic       RESX;
   logic       stall;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int last_fall = 0;
   int low_run = 0;
   int resx_len = 0;
   int resx_rise = 0;
   logic prev_busy = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       dcx;
      int         cyc;
      int         gap;
   } load_t;
   load_t load_q[$];

   typedef struct {
      logic [9:0] word;
      logic [7:0] exp_data;
      logic       exp_dcx;
   } vec_t;
   vec_t vecs[5];

   lcd_spi_sequencer #(
      .CLK_FREQ  (1000000),
      .FIFO_DEPTH(8)
   ) dut (
      .CLK_100MHz(clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .idle      (idle),
      .overflow  (overflow),
      .spi_load  (spi_load),
      .spi_data  (spi_data),
      .spi_busy  (spi_busy),
      .DCX       (DCX),
      .RESX      (RESX)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: busy for 20 cycles starting the cycle after a load; unaffected by reset.
   always @(posedge clk) begin
      if (spi_load) busy_cnt <= 20;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign spi_busy = stall || (busy_cnt > 0);

   // Monitor of loads, busy falls and RESX low pulses.
   always @(negedge clk) begin
      if (spi_load) load_q.push_back('{spi_data, DCX, cyc, cyc - last_fall});
      if (prev_busy && !spi_busy) last_fall <= cyc;
      prev_busy <= spi_busy;
      if (!RESX) low_run <= low_run + 1;
      else if (low_run > 0) begin
         resx_len  <= low_run;
         resx_rise <= cyc;
         low_run   <= 0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [9:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic wait_loads(input int n, input int budget, input string nm);
      for (int k = 0; k < budget && load_q.size() < n; k++) tick();
      chk(nm, load_q.size(), n);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      for (int k = 0; k < budget && !idle; k++) tick();
      chk(nm, int'(idle), 1);
   endtask

   initial begin
      int c0;
      int l_cyc;
      vecs[0] = '{10'h02A, 8'h2A, 1'b0};
      vecs[1] = '{10'h1FF, 8'hFF, 1'b1};
      vecs[2] = '{10'h000, 8'h00, 1'b0};
      vecs[3] = '{10'h155, 8'h55, 1'b1};
      vecs[4] = '{10'h0A5, 8'hA5, 1'b0};

      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 10'h000;
      stall   = 1'b0;
      repeat (3) tick();
      chk("rst_spi_load", int'(spi_load), 0);
      chk("rst_spi_data", int'(spi_data), 0);
      chk("rst_dcx", int'(DCX), 1);
      chk("rst_resx", int'(RESX), 1);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_full", int'(full), 0);
      reset = 1'b0;
      tick();
      chk("rst_idle", int'(idle), 1);

      // Single bytes from the table.
      foreach (vecs[i]) begin
         load_q.delete();
         c0 = cyc;
         push(vecs[i].word);
         wait_loads(1, 50, "vec_load_seen");
         if (load_q.size() >= 1) begin
            chk("vec_data", int'(load_q[0].data), int'(vecs[i].exp_data));
            chk("vec_dcx", int'(load_q[0].dcx), int'(vecs[i].exp_dcx));
            chk("vec_push_to_load", load_q[0].cyc - c0, 2);
            l_cyc = load_q[0].cyc;
            wait_idle(100, "vec_idle_seen");
            chk("vec_load_to_idle", cyc - l_cyc, 22);
         end
      end

      // Three back-to-back bytes: order, DCX and 2-cycle gap after busy falls.
      load_q.delete();
      push(10'h02C);
      push(10'h1F8);
      push(10'h100);
      wait_loads(3, 200, "b2b_loads_seen");
      wait_idle(100, "b2b_idle_seen");
      if (load_q.size() >= 3) begin
         chk("b2b_data0", int'(load_q[0].data), 32'h2C);
         chk("b2b_data1", int'(load_q[1].data), 32'hF8);
         chk("b2b_data2", int'(load_q[2].data), 32'h00);
         chk("b2b_dcx0", int'(load_q[0].dcx), 0);
         chk("b2b_dcx1", int'(load_q[1].dcx), 1);
         chk("b2b_dcx2", int'(load_q[2].dcx), 1);
         chk("b2b_gap1", load_q[1].gap, 2);
         chk("b2b_gap2", load_q[2].gap, 2);
      end

      // Reset pulse 5 ms, zero delay, then a command byte.
      load_q.delete();
      push(10'h305);
      push(10'h200);
      push(10'h011);
      repeat (100) tick();
      chk("pulse_resx_low", int'(RESX), 0);
      chk("pulse_dcx_held", int'(DCX), 1);
      chk("pulse_no_load", load_q.size(), 0);
      wait_loads(1, 7000, "pulse_load_seen");
      chk("pulse_len", resx_len, 5000);
      if (load_q.size() >= 1) begin
         chk("pulse_then_data", int'(load_q[0].data), 32'h11);
         chk("pulse_then_dcx", int'(load_q[0].dcx), 0);
         chk("zero_delay_timing", load_q[0].cyc - resx_rise, 3);
      end
      wait_idle(100, "pulse_idle_seen");

      // Stalled engine: fill, overflow on the ninth, then drain exactly eight.
      stall = 1'b1;
      load_q.delete();
      for (int i = 1; i <= 8; i++) push({2'b01, 8'(8'h10 + i)});
      chk("stall_full", int'(full), 1);
      chk("stall_ovf_before", int'(overflow), 0);
      push(10'h119);
      chk("stall_ovf_after", int'(overflow), 1);
      chk("stall_no_load", load_q.size(), 0);
      stall = 1'b0;
      wait_loads(8, 400, "drain_loads_seen");
      wait_idle(100, "drain_idle_seen");
      repeat (30) tick();
      chk("drain_count", load_q.size(), 8);
      chk("drain_not_full", int'(full), 0);
      chk("ovf_sticky", int'(overflow), 1);
      for (int i = 0; i < 8 && i < load_q.size(); i++)
         chk("drain_order", int'(load_q[i].data), int'(8'h11) + i);

      // Reset while waiting for the engine; engine keeps running.
      load_q.delete();
      push(10'h077);
      wait_loads(1, 50, "rst_mid_load_seen");
      repeat (5) tick();
      reset = 1'b1;
      #1;
      chk("rstmid_spi_data", int'(spi_data), 0);
      chk("rstmid_dcx", int'(DCX), 1);
      chk("rstmid_overflow", int'(overflow), 0);
      chk("rstmid_idle", int'(idle), 0);
      tick();
      reset = 1'b0;
      load_q.delete();
      push(10'h133);
      wait_loads(1, 60, "rstmid_reload_seen");
      if (load_q.size() >= 1) begin
         chk("rstmid_reload_data", int'(load_q[0].data), 32'h33);
         chk("rstmid_reload_gap", load_q[0].gap, 1);
      end
      wait_idle(100, "rstmid_idle_seen");

      // Reset during a pulse releases RESX without waiting for a clock.
      push(10'h301);
      repeat (10) tick();
      chk("pulse2_resx_low", int'(RESX), 0);
      reset = 1'b1;
      #1;
      chk("pulse2_async_resx", int'(RESX), 1);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("pulse2_idle", int'(idle), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
